// File: rtl/pc_control_32.sv
// Program counter register and next-PC selection for the 32-bit single-cycle MIPS core.
// Advances by +4, a taken branch (word offset) or an absolute J-type jump.
module pc_control_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        beq,
  input  logic        jump,
  input  logic [31:0] branch_addr,
  input  logic [25:0] jump_addr,
  output logic [31:0] pc
);

  localparam int unsigned PC_W = 32;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;

  assign pc_plus4      = pc_q + PC_W'(4);
  // Shift drops branch_addr[31:30]; the add wraps modulo 2^32.
  assign branch_target = pc_plus4 + {branch_addr[PC_W-3:0], 2'b00};
  // Jumps stay inside the current 256 MB region of the sequential PC.
  assign jump_target   = {pc_plus4[PC_W-1:28], jump_addr, 2'b00};

  // Next-PC priority: jump over branch over sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (jump) begin
      pc_d = jump_target;
    end else if (beq) begin
      pc_d = branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_control_32.sv
// Directed bench for pc_control_32: three instances with different reset vectors
// share one stimulus stream; expected PCs are hand-computed constants.
module tb_pc_control_32;

  logic        clk;
  logic        reset;
  logic        beq;
  logic        jump;
  logic [31:0] branch_addr;
  logic [25:0] jump_addr;
  logic [31:0] pc_a;
  logic [31:0] pc_b;
  logic [31:0] pc_c;

  int unsigned n_tests;
  int unsigned n_fail;

  pc_control_32 #(.RESET_PC(32'h0000_0000)) u_dut_a (
    .clk(clk), .reset(reset), .beq(beq), .jump(jump),
    .branch_addr(branch_addr), .jump_addr(jump_addr), .pc(pc_a)
  );

  pc_control_32 #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
    .clk(clk), .reset(reset), .beq(beq), .jump(jump),
    .branch_addr(branch_addr), .jump_addr(jump_addr), .pc(pc_b)
  );

  pc_control_32 #(.RESET_PC(32'h1000_0000)) u_dut_c (
    .clk(clk), .reset(reset), .beq(beq), .jump(jump),
    .branch_addr(branch_addr), .jump_addr(jump_addr), .pc(pc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    beq         = 1'b0;
    jump        = 1'b0;
    branch_addr = 32'd0;
    jump_addr   = 26'd0;
    #2;

    step();
    check("rst_a", pc_a, 32'h0000_0000);
    check("rst_b", pc_b, 32'hFFFF_FFF8);
    check("rst_c", pc_c, 32'h1000_0000);

    // Jump keeps the upper nibble of pc+4.
    reset = 1'b0; jump = 1'b1; jump_addr = 26'd1;
    step();
    check("jmp1_a", pc_a, 32'h0000_0004);
    check("jmp1_b", pc_b, 32'hF000_0004);
    check("jmp1_c", pc_c, 32'h1000_0004);

    reset = 1'b1; jump = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("seq4_a", pc_a, 32'd4);
    check("seq_b", pc_b, 32'hFFFF_FFFC);
    step();
    check("seq8_a", pc_a, 32'd8);
    check("wrap_b", pc_b, 32'h0000_0000);

    beq = 1'b1; branch_addr = 32'd2000;
    step();
    check("beq_fwd", pc_a, 32'd8012);
    beq = 1'b0;
    step();
    check("after_beq", pc_a, 32'd8016);

    jump = 1'b1; jump_addr = 26'd1000;
    step();
    check("jmp1000", pc_a, 32'd4000);

    // 4004 + (-976*4) = 100
    jump = 1'b0; beq = 1'b1; branch_addr = 32'hFFFF_FC30;
    step();
    check("beq_back", pc_a, 32'd100);
    branch_addr = 32'hFFFF_FFFF;
    step();
    check("beq_self", pc_a, 32'd100);
    branch_addr = 32'hFFFF_FFFE;
    step();
    check("beq_m2", pc_a, 32'd96);

    jump = 1'b1; jump_addr = 26'd5;
    step();
    check("jmp_beq", pc_a, 32'd20);

    // Reset raised between edges must wait for the edge.
    beq = 1'b0; jump = 1'b0;
    step();
    check("seq24", pc_a, 32'd24);
    #2 reset = 1'b1;
    #1;
    check("rst_mid", pc_a, 32'd24);
    step();
    check("rst_edge", pc_a, 32'd0);

    reset = 1'b0;
    step();
    check("seq_r", pc_a, 32'd4);
    reset = 1'b1; jump = 1'b1; jump_addr = 26'd5;
    step();
    check("rst_jmp_a", pc_a, 32'd0);
    check("rst_jmp_b", pc_b, 32'hFFFF_FFF8);

    // Offset bits [31:30] are shifted out.
    reset = 1'b0; jump = 1'b0; beq = 1'b1; branch_addr = 32'h4000_0001;
    step();
    check("beq_hibits", pc_a, 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
